id_scoreboard: RTL and testbench
================================

# id_scoreboard

Parametrised register scoreboard and hazard unit that sits beside the ID stage of the MIPS pipeline. It tracks every in-flight register write from issue until writeback. For each ID read port it produces a forwarding-source select (regfile, or one of FWD_STAGES downstream stages) and a load-use stall. It generalises the fixed EX/MEM two-stage comparator to any number of read ports and forwarding stages, and adds load-use interlock and pipeline-hold support.

## Interface
- NREG, 32: architectural registers; address width AW = clog2(NREG); register 0 is hard-wired zero.
- RD_PORTS, 2: number of ID read ports.
- FWD_STAGES, 2: forwardable stages after ID (1 = EX, 2 = MEM, ...); SW = clog2(FWD_STAGES+1).
- LOAD_STAGE, 2: first stage whose forwarded value is valid for a load; 1 ≤ LOAD_STAGE ≤ FWD_STAGES.

- clk  in  1  clock, rising edge.
- rst  in  1  reset rst, synchronous, active-high.
- hold_i  in  1  pipeline-wide freeze (e.g. memory wait); nothing advances.
- issue_valid_i  in  1  instruction in ID is valid.
- issue_wreg_i  in  1  that instruction writes a register.
- issue_wd_i  in  AW  destination register.
- issue_load_i  in  1  that instruction is a load.
- rd_req_i  in  RD_PORTS  per-port read enable.
- rd_addr_i  in  RD_PORTS*AW  per-port source address; port p occupies [p*AW +: AW].
- fwd_sel_o  out  RD_PORTS*SW  per-port source: 0 = regfile, k = stage k.
- stall_o  out  1  load-use stall; ID must hold and EX must receive a bubble.
- busy_o  out  NREG  per-register pending-write flags, for debug and verification.

## Operation
- State per register r: busy[r], age[r] (SW bits), load[r].
- Lookup is combinational on the current state, before this cycle's issue.
  - Port p hits if rd_req[p], addr ≠ 0 and busy[addr].
  - On a hit, the port is ready if age ≥ (load ? LOAD_STAGE : 1).
  - A ready hit gives fwd_sel = age.
  - A not-ready hit gives fwd_sel = 0 and contributes to stall.
  - A miss, an addr of 0, or rd_req = 0 gives fwd_sel = 0 and no stall.
- stall_o = OR of the not-ready hits across all ports, gated by issue_valid_i.
- Accepted issue = issue_valid & issue_wreg & ~stall_o & ~hold_i & (wd ≠ 0).
- Per-register update each edge, with advance = ~hold_i:
  - Accepted issue to r: busy=1, age=1, load=issue_load_i. This overrides the older entry for r, because the youngest writer wins.
  - Else, if busy and advance and age == FWD_STAGES: busy=0, age=0. The value is now in the regfile, which is write-before-read.
  - Else, if busy and advance: age += 1.
  - Otherwise the entry holds.
- An instruction whose source and destination are the same register looks up the old entry, then overwrites it.
- Entries age even while stall_o is high, so a stall always resolves after at most LOAD_STAGE−1 cycles.

## Timing
- Reset: all busy/age/load = 0. Consequently busy_o = 0, stall_o = 0 and fwd_sel_o = 0 during the reset cycle and the cycle after.
- Lookup latency is 0 cycles (same cycle as rd_addr). Update latency is 1 edge.
- Instruction issued at edge t: fwd_sel = 1 in cycle t..t+1, 2 in the next cycle, ..., and FWD_STAGES in the last forwardable cycle. After that the select reverts to 0.
- With defaults, a load followed immediately by a use gives exactly 1 stall cycle, then fwd_sel = 2.
- hold_i high: all entries freeze and no issue is accepted; stall_o is still computed from the frozen state.
- rst asserted mid-operation clears the scoreboard at the next edge, regardless of hold_i.
- Simultaneous issue-to-r and retirement of r: the issue wins, giving busy=1, age=1.

## Test plan
- Reset, then read r5 on both ports → fwd_sel=0, stall_o=0, busy_o=0.
- Issue ALU wd=r3, next cycle read r3 on port 0 → fwd_sel[0]=1; following cycle → 2; following → 0 and busy_o[3]=0.
- Issue load wd=r4, next cycle read r4 → stall_o=1 for 1 cycle, then fwd_sel=2 with stall_o=0. Set LOAD_STAGE=FWD_STAGES=3 → 2 stall cycles.
- Issue r7, then r7 again the next cycle, then read r7 → fwd_sel=1 (the younger writer), not 2.
- Issue r2 while hold_i=1 for 3 cycles → busy_o[2] stays 0 and existing ages are frozen; releasing hold_i resumes the sequence.
- Issue wd=r0, or read r0 while r0 is "written" → busy_o[0]=0, fwd_sel=0, stall_o=0. Assert rst with 3 entries busy → busy_o=0 after the edge.

Source files
------------

// File: rtl/id_scoreboard.sv
// Register scoreboard beside ID: tracks in-flight writes, picks forwarding
// sources per read port and raises the load-use interlock.
module id_scoreboard #(
  parameter int NREG       = 32,
  parameter int RD_PORTS   = 2,
  parameter int FWD_STAGES = 2,
  parameter int LOAD_STAGE = 2,
  localparam int AW = $clog2(NREG),
  localparam int SW = $clog2(FWD_STAGES + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   hold_i,
  input  logic                   issue_valid_i,
  input  logic                   issue_wreg_i,
  input  logic [AW-1:0]          issue_wd_i,
  input  logic                   issue_load_i,
  input  logic [RD_PORTS-1:0]    rd_req_i,
  input  logic [RD_PORTS*AW-1:0] rd_addr_i,
  output logic [RD_PORTS*SW-1:0] fwd_sel_o,
  output logic                   stall_o,
  output logic [NREG-1:0]        busy_o
);

  localparam logic [SW-1:0] ONE = SW'(1);
  localparam logic [SW-1:0] LS  = SW'(LOAD_STAGE);
  localparam logic [SW-1:0] FS  = SW'(FWD_STAGES);

  logic [NREG-1:0]         busy_q, busy_d;
  logic [NREG-1:0][SW-1:0] age_q, age_d;
  logic [NREG-1:0]         load_q, load_d;

  logic nrdy;
  logic accept;

  // Lookup sees only the registered state, never this cycle's issue.
  always_comb begin
    fwd_sel_o = '0;
    nrdy      = 1'b0;
    for (int p = 0; p < RD_PORTS; p++) begin : g_port
      logic [AW-1:0] addr;
      logic          hit;
      logic [SW-1:0] need;
      addr = rd_addr_i[p*AW +: AW];
      hit  = rd_req_i[p] && (addr != '0) && busy_q[addr];
      need = load_q[addr] ? LS : ONE;
      if (hit && (age_q[addr] >= need)) begin
        fwd_sel_o[p*SW +: SW] = age_q[addr];
      end else if (hit) begin
        nrdy = 1'b1;
      end
    end
  end

  assign stall_o = issue_valid_i & nrdy;
  assign busy_o  = busy_q;

  assign accept = issue_valid_i & issue_wreg_i & ~stall_o
                & ~hold_i & (issue_wd_i != '0);

  // A new writer to r replaces any older pending entry for r.
  always_comb begin
    busy_d = busy_q;
    age_d  = age_q;
    load_d = load_q;
    for (int r = 0; r < NREG; r++) begin
      if (accept && (issue_wd_i == AW'(r))) begin
        busy_d[r] = 1'b1;
        age_d[r]  = ONE;
        load_d[r] = issue_load_i;
      end else if (busy_q[r] && !hold_i) begin
        if (age_q[r] == FS) begin
          busy_d[r] = 1'b0;
          age_d[r]  = '0;
          load_d[r] = 1'b0;
        end else begin
          age_d[r] = age_q[r] + ONE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
      age_q  <= '0;
      load_q <= '0;
    end else begin
      busy_q <= busy_d;
      age_q  <= age_d;
      load_q <= load_d;
    end
  end

endmodule

// File: tb/tb_id_scoreboard.sv
// Directed bench for id_scoreboard: default config plus a
// LOAD_STAGE=FWD_STAGES=3 instance sharing the same stimulus.
module tb_id_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        hold;
  logic        iv;
  logic        iw;
  logic [4:0]  iwd;
  logic        il;
  logic [1:0]  req;
  logic [9:0]  addr;
  logic [3:0]  fs;
  logic        st;
  logic [31:0] bz;
  logic [3:0]  fs3;
  logic        st3;
  logic [31:0] bz3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_scoreboard dut (
    .clk(clk), .rst(rst), .hold_i(hold),
    .issue_valid_i(iv), .issue_wreg_i(iw),
    .issue_wd_i(iwd), .issue_load_i(il),
    .rd_req_i(req), .rd_addr_i(addr),
    .fwd_sel_o(fs), .stall_o(st), .busy_o(bz)
  );

  id_scoreboard #(.FWD_STAGES(3), .LOAD_STAGE(3)) dut3 (
    .clk(clk), .rst(rst), .hold_i(hold),
    .issue_valid_i(iv), .issue_wreg_i(iw),
    .issue_wd_i(iwd), .issue_load_i(il),
    .rd_req_i(req), .rd_addr_i(addr),
    .fwd_sel_o(fs3), .stall_o(st3), .busy_o(bz3)
  );

  task automatic clr();
    hold = 0; iv = 0; iw = 0; iwd = 0; il = 0;
    req = 0; addr = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic issue(input logic [4:0] wd, input logic ld);
    iv = 1; iw = 1; iwd = wd; il = ld;
  endtask

  task automatic rd(input logic [4:0] a0, input logic [4:0] a1,
                    input logic [1:0] rq);
    req = rq; addr = {a1, a0};
  endtask

  task automatic do_reset();
    clr();
    rst = 1;
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    clr();
    rst = 1;
    tick();
    rd(5'd5, 5'd5, 2'b11);
    iv = 1;
    settle();
    checks++;
    if (bz !== 32'h0 || st !== 1'b0 || fs !== 4'h0) begin
      errors++;
      $display("FAIL reset_cycle busy=%h stall=%b sel=%h want 0/0/0",
               bz, st, fs);
    end
    rst = 0;
    tick();
    settle();
    checks++;
    if (bz !== 32'h0 || st !== 1'b0 || fs !== 4'h0) begin
      errors++;
      $display("FAIL reset_after busy=%h stall=%b sel=%h want 0/0/0",
               bz, st, fs);
    end
  endtask

  task automatic test_alu_fwd();
    do_reset();
    issue(5'd3, 0);
    tick();
    clr();
    rd(5'd3, 5'd3, 2'b11);
    settle();
    checks++;
    if (fs !== 4'b0101 || st !== 1'b0) begin
      errors++;
      $display("FAIL alu_age1 sel=%h stall=%b want 5/0", fs, st);
    end
    tick();
    settle();
    checks++;
    if (fs !== 4'b1010) begin
      errors++;
      $display("FAIL alu_age2 sel=%h want a", fs);
    end
    tick();
    settle();
    checks++;
    if (fs !== 4'h0 || bz[3] !== 1'b0) begin
      errors++;
      $display("FAIL alu_retire sel=%h busy3=%b want 0/0", fs, bz[3]);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    issue(5'd4, 1);
    tick();
    clr();
    iv = 1;
    rd(5'd4, 5'd0, 2'b01);
    settle();
    checks++;
    if (st !== 1'b1 || fs !== 4'h0) begin
      errors++;
      $display("FAIL load_stall1 stall=%b sel=%h want 1/0", st, fs);
    end
    checks++;
    if (st3 !== 1'b1) begin
      errors++;
      $display("FAIL load3_stall1 stall=%b want 1", st3);
    end
    tick();
    settle();
    checks++;
    if (st !== 1'b0 || fs !== 4'h2) begin
      errors++;
      $display("FAIL load_fwd stall=%b sel=%h want 0/2", st, fs);
    end
    checks++;
    if (st3 !== 1'b1 || fs3 !== 4'h0) begin
      errors++;
      $display("FAIL load3_stall2 stall=%b sel=%h want 1/0", st3, fs3);
    end
    tick();
    settle();
    checks++;
    if (st3 !== 1'b0 || fs3 !== 4'h3) begin
      errors++;
      $display("FAIL load3_fwd stall=%b sel=%h want 0/3", st3, fs3);
    end
    clr();
  endtask

  task automatic test_younger_writer();
    do_reset();
    issue(5'd7, 0);
    tick();
    tick();
    clr();
    rd(5'd0, 5'd7, 2'b10);
    settle();
    checks++;
    if (fs !== 4'b0100 || bz[7] !== 1'b1) begin
      errors++;
      $display("FAIL younger sel=%h busy7=%b want 4/1", fs, bz[7]);
    end
  endtask

  task automatic test_hold();
    do_reset();
    issue(5'd6, 0);
    tick();
    hold = 1;
    issue(5'd2, 0);
    rd(5'd0, 5'd6, 2'b10);
    for (int i = 0; i < 3; i++) begin
      tick();
      settle();
      checks++;
      if (bz[2] !== 1'b0 || fs !== 4'b0100) begin
        errors++;
        $display("FAIL hold_%0d busy2=%b sel=%h want 0/4", i, bz[2], fs);
      end
    end
    clr();
    rd(5'd0, 5'd6, 2'b10);
    tick();
    settle();
    checks++;
    if (fs !== 4'b1000 || bz[2] !== 1'b0) begin
      errors++;
      $display("FAIL hold_resume sel=%h busy2=%b want 8/0", fs, bz[2]);
    end
  endtask

  task automatic test_r0();
    do_reset();
    issue(5'd0, 1);
    tick();
    clr();
    iv = 1;
    rd(5'd0, 5'd0, 2'b11);
    settle();
    checks++;
    if (bz !== 32'h0 || fs !== 4'h0 || st !== 1'b0) begin
      errors++;
      $display("FAIL r0 busy=%h sel=%h stall=%b want 0/0/0", bz, fs, st);
    end
  endtask

  task automatic test_same_reg();
    do_reset();
    issue(5'd5, 0);
    tick();
    issue(5'd5, 1);
    rd(5'd5, 5'd0, 2'b01);
    settle();
    checks++;
    if (fs !== 4'h1 || st !== 1'b0) begin
      errors++;
      $display("FAIL same_old sel=%h stall=%b want 1/0", fs, st);
    end
    tick();
    iw = 0;
    settle();
    checks++;
    if (st !== 1'b1 || fs !== 4'h0) begin
      errors++;
      $display("FAIL same_new stall=%b sel=%h want 1/0", st, fs);
    end
    clr();
  endtask

  task automatic test_back_to_back();
    do_reset();
    issue(5'd9, 0);
    tick();
    clr();
    tick();
    issue(5'd9, 0);
    tick();
    clr();
    rd(5'd9, 5'd0, 2'b01);
    settle();
    checks++;
    if (fs !== 4'h1 || bz[9] !== 1'b1) begin
      errors++;
      $display("FAIL retire_vs_issue sel=%h busy9=%b want 1/1", fs, bz[9]);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    issue(5'd1, 0);
    tick();
    issue(5'd2, 0);
    tick();
    issue(5'd3, 0);
    tick();
    clr();
    settle();
    checks++;
    if (bz3 !== 32'h0000_000E || bz !== 32'h0000_000C) begin
      errors++;
      $display("FAIL pre_rst busy=%h busy3=%h want c/e", bz, bz3);
    end
    hold = 1;
    rst = 1;
    tick();
    rst = 0;
    hold = 0;
    settle();
    checks++;
    if (bz !== 32'h0 || bz3 !== 32'h0) begin
      errors++;
      $display("FAIL mid_rst busy=%h busy3=%h want 0/0", bz, bz3);
    end
  endtask

  initial begin
    clr();
    rst = 1;
    test_reset();
    test_alu_fwd();
    test_load_use();
    test_younger_writer();
    test_hold();
    test_r0();
    test_same_reg();
    test_back_to_back();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
